// File: rtl/arbitro_barramento.sv
// Round-robin arbiter for four requesters sharing the 4:1 datapath mux.
// Registers the owner's word onto saida and bounds each grant by MAX_HOLD.
module arbitro_barramento #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       done,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  input  logic [WIDTH-1:0] entrada3,
  input  logic [WIDTH-1:0] entrada4,
  output logic [1:0]       controle,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] saida,
  output logic             valido,
  output logic             expirou
);

  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;

  localparam bit         LIMITADO = (MAX_HOLD != 0);
  localparam logic [7:0] LIM      = 8'(MAX_HOLD - 1);

  estado_t          estado, estado_n;
  logic [1:0]       ptr, ptr_n, controle_n, vencedor;
  logic [3:0]       gnt_n;
  logic [7:0]       cont, cont_n;
  logic [WIDTH-1:0] saida_n, dado;
  logic             valido_n, expirou_n;
  logic             achou, liberar, estouro, por_done, por_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      ptr      <= '0;
      controle <= '0;
      gnt      <= '0;
      cont     <= '0;
      saida    <= '0;
      valido   <= 1'b0;
      expirou  <= 1'b0;
    end else begin
      estado   <= estado_n;
      ptr      <= ptr_n;
      controle <= controle_n;
      gnt      <= gnt_n;
      cont     <= cont_n;
      saida    <= saida_n;
      valido   <= valido_n;
      expirou  <= expirou_n;
    end
  end

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    achou    = 1'b0;
    vencedor = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        achou    = 1'b1;
        vencedor = ptr + 2'(k);
      end
    end
    por_done = |(done & gnt);
    por_req  = ~|(req & gnt);
    estouro  = LIMITADO && (cont == LIM);
    liberar  = por_done | por_req | estouro;
    estado_n = estado;
    unique case (estado)
      OCIOSO:    if (achou) estado_n = CONCEDIDO;
      CONCEDIDO: if (liberar) estado_n = OCIOSO;
      default:   estado_n = OCIOSO;
    endcase
  end

  always_comb begin
    dado = '0;
    unique case (1'b1)
      gnt[0]:  dado = entrada1;
      gnt[1]:  dado = entrada2;
      gnt[2]:  dado = entrada3;
      gnt[3]:  dado = entrada4;
      default: dado = '0;
    endcase
  end

  always_comb begin
    gnt_n      = gnt;
    controle_n = controle;
    ptr_n      = ptr;
    cont_n     = cont;
    saida_n    = saida;
    valido_n   = 1'b0;
    expirou_n  = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (achou) begin
          gnt_n      = 4'b0001 << vencedor;
          controle_n = vencedor;
          ptr_n      = vencedor + 2'd1;
          cont_n     = '0;
        end
      end
      CONCEDIDO: begin
        saida_n  = dado;
        valido_n = 1'b1;
        if (cont != 8'hFF) cont_n = cont + 8'd1;
        if (liberar) begin
          gnt_n     = '0;
          expirou_n = estouro & ~por_done & ~por_req;
        end
      end
      default: gnt_n = '0;
    endcase
  end

endmodule

// File: doc/arbitro_barramento.md
# arbitro_barramento

Round-robin arbiter for four requesters sharing one 8-bit 4:1 datapath mux in the nRISC core. It grants the shared path to one requester at a time and drives the mux's 2-bit `controle` select. It registers the selected word onto `saida` with a valid flag and bounds each grant with a hold timeout. It sits between the requesting units and the existing 2-bit-select mux, replacing hard-wired select logic.

## Interface
- `WIDTH`, 8: data width of each `entrada` and of `saida`.
- `MAX_HOLD`, 15: maximum cycles per grant, range 1..255; 0 = no limit.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 4: request, bit i = requester i; level, held while access is wanted.
- `done` in 4: release strobe, bit i = requester i; only the owner's bit is honoured.
- `entrada1`..`entrada4` in WIDTH each: data of requesters 0..3.
- `controle` out 2: mux select = index of current owner, registered.
- `gnt` out 4: one-hot grant, registered; all-zero when idle.
- `saida` out WIDTH: registered selected data.
- `valido` out 1: `saida` carries owner data captured this cycle.
- `expirou` out 1: one-cycle pulse when a grant is forcibly ended by timeout.

## Operation
- States:
  - OCIOSO: no owner, `gnt` = 0.
  - CONCEDIDO: one owner.
- Round-robin pointer `ptr` (2 bits) gives the first index checked. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- OCIOSO:
  - If any `req` bit is set, pick the first set bit in search order as owner i.
  - Next edge: state becomes CONCEDIDO, `gnt` = one-hot(i), `controle` = i, `ptr` = (i+1) mod 4, hold counter = 0.
- CONCEDIDO, every edge:
  - Capture `saida` from the owner's entrada (entrada{i+1}) and set `valido` = 1.
  - Hold counter increments, saturating at 8 bits.
- Release at an edge when any of the following holds at that edge:
  - `done[i]` = 1;
  - `req[i]` = 0;
  - `MAX_HOLD` ≠ 0 and counter = MAX_HOLD−1.
- On release:
  - State becomes OCIOSO and `gnt` becomes 0 at that edge.
  - `controle` holds its last value.
  - `saida` still captures the owner data on the releasing edge.
- `expirou` = 1 for the cycle after release only if the timeout was the sole cause. If `done[i]` or a dropped `req[i]` coincides with the timeout, `expirou` stays 0.
- `done` bits of non-owners are ignored. `req` changes of non-owners have no effect during CONCEDIDO.
- At least one OCIOSO cycle (bus turnaround) always separates two grants, even if the same or another requester is waiting.
- `saida` holds its last value while `valido` = 0.

## Timing
- Reset (any state, including mid-grant), values after the edge:
  - state OCIOSO, `gnt` = 0, `controle` = 0, `ptr` = 0;
  - `saida` = 0, `valido` = 0, `expirou` = 0, counter = 0.
- Request sampled at edge k (idle) → `gnt`/`controle` valid after k+1 → first `saida` with `valido` = 1 after k+2.
- Grant length: with no `done` and `req` held, `gnt` stays high exactly MAX_HOLD cycles.
- Release at edge m:
  - `gnt` = 0 after m;
  - `valido` falls after m+1;
  - `expirou`, if applicable, is high m→m+1;
  - earliest next grant after m+1.
- `req[i]` that rises and falls between edges is not seen. Only edge-sampled values count.

## Test plan
- Reset, then `req` = 4'b0001, `entrada1` = 8'hA5:
  - after 1 edge: `gnt` = 0001, `controle` = 0;
  - after 2 edges: `saida` = A5, `valido` = 1.
- `req` = 4'b1111 held, `done` = 0, MAX_HOLD = 3:
  - grant order 0,1,2,3,0;
  - each grant lasts 3 cycles followed by 1 idle cycle;
  - `expirou` pulses after each grant.
- Owner 2 with `ptr` = 3 and `req` = 4'b0101:
  - owner 2 asserts `done[2]` → after release, next grant goes to 0 (wrap-around);
  - `expirou` stays 0.
- Timeout and `done[owner]` on the same edge (MAX_HOLD = 4, `done` in 4th cycle) → release, `expirou` = 0.
- Non-owner `done[3]` pulse while requester 1 owns → no change to `gnt`, `controle`, `valido`.
- `reset` asserted in the middle of a grant to requester 2 → after that edge `gnt` = 0, `valido` = 0, `saida` = 0, `controle` = 0. With `req` = 4'b0110 still held, next grant goes to 1 (ptr = 0).
